// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the Decode stage.
//   x0 reads as zero and ignores writes.
//   A per-register pending scoreboard feeds the hazard unit.
//   A sequential sweep zeroes the file on request.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ra / rd / rpend  NUM_RD combinational read ports: address, data, pending flag
//   we / wa / wd     NUM_WR write ports; the higher port index wins on a collision
//   iss_en / iss_rd  issue: marks iss_rd pending
//   clr_req          starts a clear sweep
//   clr_busy         high while the sweep runs
//   a0               contents of register A0_INDEX
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_mp #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned NUM_WR        = 1,
  parameter int unsigned A0_INDEX      = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   ra,
  output logic [NUM_RD*DATA_WIDTH-1:0]      rd,
  output logic [NUM_RD-1:0]                 rpend,
  input  logic [NUM_WR-1:0]                 we,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0]      wd,
  input  logic                              iss_en,
  input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
  input  logic                              clr_req,
  output logic                              clr_busy,
  output logic [DATA_WIDTH-1:0]             a0
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [ADDRESS_WIDTH-1:0] IDX_FIRST = ADDRESS_WIDTH'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]         pend_q;

  // FSM state and sweep index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: sweep starts at x1, x0 is never stored
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = IDX_FIRST;
        end
      end
      ST_SWEEP: begin
        idx_d = idx_q + ADDRESS_WIDTH'(1);
        if (idx_q == IDX_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage and scoreboard; loop order makes the higher write port win,
  // and the issue update comes last so a newer producer keeps the bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else if (state_q == ST_SWEEP) begin
      mem_q[idx_q] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (we[w] && (wa[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
          mem_q[wa[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]]  <= wd[w*DATA_WIDTH +: DATA_WIDTH];
          pend_q[wa[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= 1'b0;
        end
      end
      if (clr_req) begin
        pend_q <= '0;
      end else if (iss_en && (iss_rd != '0)) begin
        pend_q[iss_rd] <= 1'b1;
      end
    end
  end

  // Read ports
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     pend;

    assign addr = ra[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      data = mem_q[addr];
      pend = pend_q[addr];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed during a sweep, when writes are dropped
      if (state_q == ST_IDLE) begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (we[w] && (wa[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == addr)) begin
            data = wd[w*DATA_WIDTH +: DATA_WIDTH];
            pend = iss_en && (iss_rd == addr);
          end
        end
      end
`endif
      if (addr == '0) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rd[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rpend[p]                       = pend;
  end

  assign clr_busy = (state_q == ST_SWEEP);
  assign a0       = mem_q[ADDRESS_WIDTH'(A0_INDEX)];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (two read, two write ports).
module tb_regfile_mp;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [2*AW-1:0] ra;
  logic [2*DW-1:0] rd;
  logic [1:0]    rpend;
  logic [1:0]    we;
  logic [2*AW-1:0] wa;
  logic [2*DW-1:0] wd;
  logic          iss_en;
  logic [AW-1:0] iss_rd;
  logic          clr_req;
  logic          clr_busy;
  logic [DW-1:0] a0;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt;
  logic [31:0] exp_byp;

  regfile_mp #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2), .NUM_WR(2), .A0_INDEX(10)
  ) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rpend(rpend),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p]          = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0;
    iss_en = 1'b0; iss_rd = '0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(clr_busy), 32'h0);
    check("rst_a0", a0, 32'h0);
    rst = 1'b0;
    tick;

    // Everything reads zero after reset
    for (int a = 0; a < 32; a++) begin
      set_ra(0, AW'(a)); set_ra(1, AW'(a));
      #1;
      check("rst_rd", rd[31:0], 32'h0);
      check("rst_rpend", 32'(rpend[0]), 32'h0);
    end

    // Basic write, x0 write dropped
    wr(0, 5'd5, 32'hDEADBEEF); tick; we = '0;
    set_ra(0, 5'd5); #1;
    check("wr_x5", rd[31:0], 32'hDEADBEEF);
    wr(0, 5'd0, 32'h1234); tick; we = '0;
    set_ra(0, 5'd0); set_ra(1, 5'd5); #1;
    check("wr_x0", rd[31:0], 32'h0);
    check("x5_kept", rd[63:32], 32'hDEADBEEF);

    // Two ports, same address: port 1 wins
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); tick; we = '0;
    set_ra(0, 5'd7); #1;
    check("wr_collide", rd[31:0], 32'h22);

    // Scoreboard
    iss_en = 1'b1; iss_rd = 5'd9; tick; iss_en = 1'b0;
    set_ra(1, 5'd9); #1;
    check("pend_set", 32'(rpend[1]), 32'h1);
    tick;
    check("pend_hold", 32'(rpend[1]), 32'h1);
    wr(0, 5'd9, 32'h99); tick; we = '0; #1;
    check("pend_clr", 32'(rpend[1]), 32'h0);
    check("wr_x9", rd[63:32], 32'h99);
    iss_en = 1'b1; iss_rd = 5'd9; wr(1, 5'd9, 32'hAA); tick; iss_en = 1'b0; we = '0; #1;
    check("pend_iss_wins", 32'(rpend[1]), 32'h1);
    check("wr_x9_b", rd[63:32], 32'hAA);

    // Clear sweep with writes and issues attempted throughout
    wr(0, 5'd10, 32'h55); tick; we = '0; #1;
    check("a0_pre", a0, 32'h55);
    clr_req = 1'b1; tick; clr_req = 1'b0;
    set_ra(0, 5'd5); set_ra(1, 5'd9);
    wr(0, 5'd12, 32'hFF); iss_en = 1'b1; iss_rd = 5'd13;
    #1;
    check("sweep_partial", rd[31:0], 32'hDEADBEEF);
    check("sweep_pend_clr", 32'(rpend[1]), 32'h0);
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick;
    end
    check("sweep_len", 32'(cnt), 32'd31);
    we = '0; iss_en = 1'b0; #1;
    for (int a = 0; a < 32; a++) begin
      set_ra(0, AW'(a)); set_ra(1, AW'(a));
      #1;
      check("swept_rd", rd[31:0], 32'h0);
      check("swept_pend", 32'(rpend[1]), 32'h0);
    end
    check("a0_post", a0, 32'h0);
    wr(0, 5'd4, 32'h44); tick; we = '0;
    set_ra(0, 5'd4); #1;
    check("wr_after_sweep", rd[31:0], 32'h44);

    // Reset during a sweep
    wr(0, 5'd30, 32'h77); tick; we = '0;
    clr_req = 1'b1; tick; clr_req = 1'b0;
    repeat (3) tick;
    check("busy_mid", 32'(clr_busy), 32'h1);
    rst = 1'b1; set_ra(0, 5'd30); #1;
    check("rst_mid_busy", 32'(clr_busy), 32'h0);
    check("rst_mid_x30", rd[31:0], 32'h0);
    check("rst_mid_x4", 32'(dut.mem_q[4]), 32'h0);
    tick; rst = 1'b0; tick;
    check("rst_mid_idle", 32'(clr_busy), 32'h0);

    // Same-cycle write/read of x3
    wr(0, 5'd3, 32'h33); tick; we = '0; #1;
    wr(0, 5'd3, 32'hA5); set_ra(0, 5'd3); #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5;
`else
    exp_byp = 32'h33;
`endif
    check("same_cycle_rd", rd[31:0], exp_byp);
    tick; we = '0; #1;
    check("after_edge_rd", rd[31:0], 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined RV32 core's Decode stage. Provides NUM_RD combinational read ports and NUM_WR write ports, with x0 hard-wired to zero. Includes a per-register pending scoreboard for hazard detection and a sequential clear engine that zeroes the file on request. Sits between the Decode read stage (RD ports) and Writeback (WR ports); the hazard unit consumes the pending flags.

## Interface
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register width
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- A0_INDEX, 10, register mirrored on the a0 debug output
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ra  in  NUM_RD*ADDRESS_WIDTH  read addresses; port p uses slice p
- rd  out  NUM_RD*DATA_WIDTH  read data; port p uses slice p
- rpend  out  NUM_RD  pending flag of the register addressed by ra slice p
- we  in  NUM_WR  write enables
- wa  in  NUM_WR*ADDRESS_WIDTH  write addresses
- wd  in  NUM_WR*DATA_WIDTH  write data
- iss_en  in  1  issue: marks register iss_rd as pending
- iss_rd  in  ADDRESS_WIDTH  destination of the issuing instruction
- clr_req  in  1  single-cycle request to start a clear sweep
- clr_busy  out  1  high while the sweep runs
- a0  out  DATA_WIDTH  contents of register A0_INDEX

## Operation
- Reset: all registers 0, all pending bits 0, FSM in IDLE, clr_busy 0, a0 0.
- Reads are combinational. Address 0 always returns 0, and rpend for address 0 is always 0.
- A write with we[w]=1 and a nonzero wa stores wd at the clock edge and clears that register's pending bit.
- Writes to x0 are dropped.
- Two write ports on the same address in the same cycle: the higher port index wins.
- iss_en with a nonzero iss_rd sets pending[iss_rd] at the edge.
- Issue and write to the same register in the same cycle: pending stays 1. The issue wins because it names the newer producer.
- FSM states:
  - IDLE: clr_req=1 goes to SWEEP. All pending bits clear at that edge, and idx loads 1.
  - SWEEP: at each edge, register idx is written to 0 and idx increments. After idx = 2**ADDRESS_WIDTH-1 is cleared, the FSM returns to IDLE.
- While in SWEEP:
  - we, iss_en and clr_req are ignored.
  - Reads return current contents, so the file is partially cleared mid-sweep.
  - clr_busy is 1 only in SWEEP.
- Reset asserted mid-sweep returns the FSM to IDLE immediately, with all state zeroed.

## Timing
- Read latency is 0 cycles, combinational from ra.
- Write latency: data is visible on rd the cycle after the we edge.
- Pending set and clear become visible one cycle after the edge.
- Clear sweep: clr_req sampled high at edge N. clr_busy is high for cycles N+1 through N+2**ADDRESS_WIDTH-1, which is 31 cycles at the default depth. we is accepted again from the first cycle clr_busy is low.
- a0 follows register A0_INDEX with no extra delay.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-cycle write (we=1, wa=ra≠0) is forwarded to rd combinationally, with the higher write port winning.
  - rpend for that read port reads 0 unless iss_en targets the same register in that cycle.
- REGFILE_BYPASS_EN undefined: rd returns the stored value until the edge, and no forwarding logic is present.
- While clr_busy=1, no bypass occurs in either build.

## Test plan
- Reset, then read all 32 addresses -> every rd=0, every rpend=0, a0=0.
- Write x5=0xDEADBEEF, then read x5 next cycle -> rd=0xDEADBEEF. Write x0=0x1234 -> x0 still reads 0.
- Write x7 on port0=0x11 and port1=0x22 in the same cycle -> x7=0x22.
- Issue x9, then write x9 two cycles later:
  - rpend(x9) is 1 in between and 0 after the write.
  - Issue plus write of x9 in the same cycle -> rpend stays 1.
- Write x10=0x55, then clr_req:
  - a0=0x55 before the sweep.
  - clr_busy is high for exactly 31 cycles, and a writes during those cycles are dropped.
  - All registers read 0 afterwards.
  - Asserting rst at sweep cycle 4 -> clr_busy drops at once.
- With REGFILE_BYPASS_EN, write x3=0xA5 while reading x3 in the same cycle -> rd=0xA5 that cycle. Without the macro -> rd returns the old value.
